// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with valid/ready byte output and error pulses
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             rx_m;
  logic             rx_s;

  // Two-flop synchronizer for the asynchronous pin; idles high like the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM plus output register, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Decision lands HALF cycles after START is entered, i.e. mid start bit
        // relative to the detected edge; every later sample is one bit apart.
        START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            idx <= 3'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Leave at mid stop bit so a following start edge can be caught with no gap.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              overrun  <= rx_valid && !rx_ready;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - scoreboard bench for uart_rx_8n1
module tb_uart_rx_8n1;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_8n1 #(.CLKS_PER_BIT(C), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int valid_rises = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  int rise_q[$];
  int t0, v0, vc0, fe0, ov0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && !prev_valid) begin
        valid_rises++;
        rise_q.push_back(cyc);
      end
      if (frame_err) fe_cycles++;
      if (overrun) ov_cycles++;
      if (rx_valid && rx_ready) begin
        check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      prev_valid = rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is 1ns after a rising edge; rst_bit selects a frame bit (0=start) to pulse reset in.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == rst_bit) begin
        repeat (C / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (C / 2 - 1) @(posedge clk);
        #1;
      end else begin
        repeat (C) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic snap();
    v0 = valid_rises; vc0 = valid_cycles; fe0 = fe_cycles; ov0 = ov_cycles;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_data", 32'(rx_data), 32'h00);
    check_eq("rst_fe", 32'(frame_err), 32'd0);
    check_eq("rst_ov", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(5);
    check_eq("idle_state", 32'(dut.state), 32'd0);

    // exact latency and zero-gap back-to-back frames
    rise_q.delete();
    snap();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    t0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    idle(2 * C);
    check_eq("gap_rises", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() >= 2) begin
      check_eq("lat_first", 32'(rise_q[0] - t0), 32'd156);
      check_eq("lat_second", 32'(rise_q[1] - rise_q[0]), 32'd160);
    end
    check_eq("gap_drain", 32'(exp_q.size()), 32'd0);

    // nominal: ten identical frames
    snap();
    for (int n = 0; n < 10; n++) begin
      exp_q.push_back(8'h54);
      send_frame(8'h54, 1'b1, -1);
      idle(2);
    end
    idle(2 * C);
    check_eq("nom_rises", 32'(valid_rises - v0), 32'd10);
    check_eq("nom_width", 32'(valid_cycles - vc0), 32'd10);
    check_eq("nom_fe", 32'(fe_cycles - fe0), 32'd0);
    check_eq("nom_ov", 32'(ov_cycles - ov0), 32'd0);
    check_eq("nom_drain", 32'(exp_q.size()), 32'd0);

    // glitch rejection
    snap();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(2 * C);
    check_eq("gl_state", 32'(dut.state), 32'd0);
    check_eq("gl_valid", 32'(valid_rises - v0), 32'd0);
    check_eq("gl_fe", 32'(fe_cycles - fe0), 32'd0);
    check_eq("gl_ov", 32'(ov_cycles - ov0), 32'd0);

    // framing error then a good frame
    snap();
    send_frame(8'hFF, 1'b0, -1);
    idle(2 * C);
    check_eq("fe_pulse", 32'(fe_cycles - fe0), 32'd1);
    check_eq("fe_valid", 32'(valid_rises - v0), 32'd0);
    check_eq("fe_valid_lvl", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1);
    idle(2 * C);
    check_eq("fe_next_drain", 32'(exp_q.size()), 32'd0);
    check_eq("fe_next_rise", 32'(valid_rises - v0), 32'd1);

    // overrun with consumer stalled
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1);
    idle(C);
    send_frame(8'h22, 1'b1, -1);
    idle(C);
    check_eq("ov_pulse", 32'(ov_cycles - ov0), 32'd1);
    check_eq("ov_fe", 32'(fe_cycles - fe0), 32'd0);
    check_eq("ov_valid", 32'(rx_valid), 32'd1);
    check_eq("ov_data", 32'(rx_data), 32'h22);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ov_cleared", 32'(rx_valid), 32'd0);
    check_eq("ov_drain", 32'(exp_q.size()), 32'd0);

    // reset during data bit 4 aborts the frame
    snap();
    send_frame(8'hF5, 1'b1, 5);
    idle(2 * C);
    check_eq("rm_rises", 32'(valid_rises - v0), 32'd0);
    check_eq("rm_valid", 32'(rx_valid), 32'd0);
    check_eq("rm_data", 32'(rx_data), 32'h00);
    check_eq("rm_fe", 32'(fe_cycles - fe0), 32'd0);
    check_eq("rm_ov", 32'(ov_cycles - ov0), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1);
    idle(2 * C);
    check_eq("rm_next_rise", 32'(valid_rises - v0), 32'd1);
    check_eq("rm_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
